// File: rtl/instr_register_ctrl.sv
// Instruction register controller.
// Runs a 32-entry instruction register as a circular queue. Two requesters
// compete for one write slot per cycle and one consumer reads the oldest
// entry. Write and read side effects appear one cycle after acceptance.
// Optional feature macro: INSTR_CTRL_RR_EN selects round-robin arbitration.
// Without it, arbitration is fixed priority with req0 winning.

package instr_register_pkg;
    typedef enum logic [3:0] {
        ZERO  = 4'd0,
        PASSA = 4'd1,
        PASSB = 4'd2,
        ADD   = 4'd3,
        SUB   = 4'd4,
        MULT  = 4'd5,
        DIV   = 4'd6,
        MOD   = 4'd7
    } opcode_t;
    typedef logic signed [31:0] operand_t;
    typedef logic [4:0]         address_t;
endpackage

module instr_register_ctrl
    import instr_register_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       req0_valid,
    input  opcode_t    req0_opcode,
    input  operand_t   req0_op_a,
    input  operand_t   req0_op_b,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  opcode_t    req1_opcode,
    input  operand_t   req1_op_a,
    input  operand_t   req1_op_b,
    output logic       req1_ready,
    input  logic       rd_req,
    output logic       rd_ready,
    output logic       rd_valid,
    output logic       load_en,
    output address_t   write_pointer,
    output address_t   read_pointer,
    output operand_t   operand_a,
    output operand_t   operand_b,
    output opcode_t    opcode,
    output logic [5:0] count,
    output logic       full,
    output logic       empty
);

    address_t   wp_q, wp_d;
    address_t   rp_q, rp_d;
    logic [5:0] count_q, count_d;
    logic       load_en_q, load_en_d;
    logic       rd_valid_q, rd_valid_d;
    address_t   write_pointer_q, write_pointer_d;
    address_t   read_pointer_q, read_pointer_d;
    operand_t   operand_a_q, operand_a_d;
    operand_t   operand_b_q, operand_b_d;
    opcode_t    opcode_q, opcode_d;

    logic grant0;
    logic grant1;
    logic wr_acc;
    logic rd_acc;
    logic full_w;
    logic empty_w;

    // Status is derived from the registered occupancy only, so a read in the
    // same cycle never frees a slot for a write in that cycle.
    assign full_w  = (count_q == 6'd32);
    assign empty_w = (count_q == 6'd0);

`ifdef INSTR_CTRL_RR_EN
    // 1 = req1 was granted last, 0 = req0 was granted last.
    logic last1_q, last1_d;

    // Round-robin: on contention grant whoever was not granted last.
    always_comb begin
        grant0  = req0_valid && (!req1_valid || last1_q);
        grant1  = req1_valid && (!req0_valid || !last1_q);
        last1_d = last1_q;
        if (wr_acc) begin
            last1_d = grant1;
        end
    end

    // Arbitration pointer; advances only when a write is actually accepted.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last1_q <= 1'b1;
        end else begin
            last1_q <= last1_d;
        end
    end
`else
    // Fixed priority: req0 always wins on contention.
    always_comb begin
        grant0 = req0_valid;
        grant1 = req1_valid && !req0_valid;
    end
`endif

    assign wr_acc     = (grant0 || grant1) && !full_w;
    assign rd_acc     = rd_req && !empty_w;
    assign req0_ready = grant0 && !full_w;
    assign req1_ready = grant1 && !full_w;
    assign rd_ready   = !empty_w;

    // Next-state for queue pointers, occupancy and the register-drive outputs.
    always_comb begin
        wp_d            = wp_q;
        rp_d            = rp_q;
        count_d         = count_q;
        load_en_d       = wr_acc;
        rd_valid_d      = rd_acc;
        write_pointer_d = write_pointer_q;
        read_pointer_d  = read_pointer_q;
        operand_a_d     = operand_a_q;
        operand_b_d     = operand_b_q;
        opcode_d        = opcode_q;

        if (wr_acc) begin
            wp_d            = wp_q + 5'd1;
            write_pointer_d = wp_q;
            if (grant0) begin
                opcode_d    = req0_opcode;
                operand_a_d = req0_op_a;
                operand_b_d = req0_op_b;
            end else begin
                opcode_d    = req1_opcode;
                operand_a_d = req1_op_a;
                operand_b_d = req1_op_b;
            end
        end

        if (rd_acc) begin
            rp_d           = rp_q + 5'd1;
            read_pointer_d = rp_q;
        end

        if (wr_acc && !rd_acc) begin
            count_d = count_q + 6'd1;
        end else if (rd_acc && !wr_acc) begin
            count_d = count_q - 6'd1;
        end
    end

    // State registers; reset clears everything, dropping any in-flight transfer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wp_q            <= '0;
            rp_q            <= '0;
            count_q         <= '0;
            load_en_q       <= 1'b0;
            rd_valid_q      <= 1'b0;
            write_pointer_q <= '0;
            read_pointer_q  <= '0;
            operand_a_q     <= '0;
            operand_b_q     <= '0;
            opcode_q        <= ZERO;
        end else begin
            wp_q            <= wp_d;
            rp_q            <= rp_d;
            count_q         <= count_d;
            load_en_q       <= load_en_d;
            rd_valid_q      <= rd_valid_d;
            write_pointer_q <= write_pointer_d;
            read_pointer_q  <= read_pointer_d;
            operand_a_q     <= operand_a_d;
            operand_b_q     <= operand_b_d;
            opcode_q        <= opcode_d;
        end
    end

    assign load_en       = load_en_q;
    assign rd_valid      = rd_valid_q;
    assign write_pointer = write_pointer_q;
    assign read_pointer  = read_pointer_q;
    assign operand_a     = operand_a_q;
    assign operand_b     = operand_b_q;
    assign opcode        = opcode_q;
    assign count         = count_q;
    assign full          = full_w;
    assign empty         = empty_w;

endmodule
